// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED sequence controller: FSM states,
// pattern modes, bounce direction and the per-mode seed pattern.
package led_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CHASE  = 2'd0,
    COUNT  = 2'd1,
    BOUNCE = 2'd2,
    BLINK  = 2'd3
  } mode_t;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } dir_t;

  localparam int unsigned NUM_MODES = 4;

  // Seed is returned 16 bits wide (widest legal bank) and masked to the bank width.
  function automatic logic [15:0] seed_of(input mode_t m, input int unsigned num_leds);
    logic [16:0] mask;
    logic [15:0] seed;
    mask = (17'd1 << num_leds) - 17'd1;
    seed = (m == CHASE || m == BOUNCE) ? 16'd1 : 16'd0;
    return mask[15:0] & seed;
  endfunction

endpackage

// File: rtl/IBUFGDS.sv
// Behavioural model of the differential global clock input buffer, used for
// simulation and lint; synthesis binds the vendor primitive of the same name.
module IBUFGDS (
  input  logic I,
  input  logic IB,
  output logic O
);

  assign O = I & ~IB;

endmodule

// File: rtl/switch_debouncer.sv
// One slide switch: 2-FF synchronizer, debounce filter and 1->0 release pulse.
// The debounce counter exists only when LED_SEQ_DEBOUNCE_EN is defined.
module switch_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic s_clk,
  input  logic rst,
  input  logic sw,
  output logic rel
);

  logic sync_p0;
  logic sync_p1;
  logic level;
  logic level_d;

  // Stage p0/p1: metastability guard for the asynchronous switch
  always_ff @(posedge s_clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= sw;
      sync_p1 <= sync_p0;
    end
  end

`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Debounce stage: level follows sync_p1 only after an uninterrupted run of mismatches
  always_ff @(posedge s_clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_p1 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= sync_p1;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
`else
  logic unused_debounce;

  assign level           = sync_p1;
  assign unused_debounce = (DEBOUNCE_CYCLES == 0);
`endif

  // Release stage: registered one-cycle pulse on the accepted 1->0 transition
  always_ff @(posedge s_clk or posedge rst) begin
    if (rst) begin
      level_d <= 1'b0;
      rel     <= 1'b0;
    end else begin
      level_d <= level;
      rel     <= level_d & ~level;
    end
  end

endmodule

// File: rtl/led_sequence_controller.sv
// LED bank sequencer: run/pause FSM on sw[0] releases, mode advance on sw[1],
// four patterns stepped every STEP_CYCLES. Debouncing enabled by LED_SEQ_DEBOUNCE_EN.
module led_sequence_controller
  import led_seq_pkg::*;
#(
  parameter int unsigned NUM_LEDS        = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned STEP_CYCLES     = 50_000_000
) (
  input  logic                sysclk_p,
  input  logic                sysclk_n,
  input  logic                rst,
  input  logic [1:0]          sw,
  output logic [NUM_LEDS-1:0] led
);

  localparam int unsigned STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

  logic s_clk;
  logic rel0;
  logic rel1;

  state_t              state_q, state_n;
  mode_t               mode_q, mode_n;
  dir_t                dir_q, dir_n;
  logic [STEP_W-1:0]   cnt_q, cnt_n;
  logic [NUM_LEDS-1:0] pat_q, pat_n;
  logic [NUM_LEDS-1:0] adv;
  logic [15:0]         seed_w;

  IBUFGDS u_ibufgds (
    .I  (sysclk_p),
    .IB (sysclk_n),
    .O  (s_clk)
  );

  switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw0 (
    .s_clk (s_clk),
    .rst   (rst),
    .sw    (sw[0]),
    .rel   (rel0)
  );

  switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw1 (
    .s_clk (s_clk),
    .rst   (rst),
    .sw    (sw[1]),
    .rel   (rel1)
  );

  function automatic logic [NUM_LEDS-1:0] advance(input logic [NUM_LEDS-1:0] p,
                                                  input mode_t m, input dir_t d);
    case (m)
      CHASE:   return {p[NUM_LEDS-2:0], p[NUM_LEDS-1]};
      COUNT:   return p + NUM_LEDS'(1);
      BOUNCE:  return (d == RIGHT) ? (p >> 1) : (p << 1);
      default: return ~p;
    endcase
  endfunction

  always_ff @(posedge s_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= CHASE;
      dir_q   <= LEFT;
      cnt_q   <= '0;
      pat_q   <= '0;
    end else begin
      state_q <= state_n;
      mode_q  <= mode_n;
      dir_q   <= dir_n;
      cnt_q   <= cnt_n;
      pat_q   <= pat_n;
    end
  end

  always_comb begin
    state_n = state_q;
    mode_n  = mode_q;
    dir_n   = dir_q;
    cnt_n   = cnt_q;
    pat_n   = pat_q;
    adv     = advance(pat_q, mode_q, dir_q);
    seed_w  = seed_of(mode_q, NUM_LEDS);

    case (state_q)
      IDLE: begin
        pat_n = '0;
        cnt_n = '0;
        if (rel0) begin
          state_n = RUN;
          pat_n   = seed_w[NUM_LEDS-1:0];
          dir_n   = LEFT;
        end
      end
      RUN: begin
        if (cnt_q == STEP_LAST) begin
          cnt_n = '0;
          pat_n = adv;
          // Bounce turns around at either end so the next step moves inward
          if (mode_q == BOUNCE) begin
            if (dir_q == LEFT && adv[NUM_LEDS-1]) dir_n = RIGHT;
            else if (dir_q == RIGHT && adv[0])    dir_n = LEFT;
          end
        end else begin
          cnt_n = cnt_q + STEP_W'(1);
        end
        if (rel0) state_n = PAUSE;
      end
      PAUSE: begin
        if (rel0) state_n = RUN;
      end
      default: state_n = IDLE;
    endcase

    // Mode advance overrides any step in the same cycle and reseeds an active pattern
    if (rel1) begin
      mode_n = mode_t'(mode_q + 2'd1);
      cnt_n  = '0;
      seed_w = seed_of(mode_n, NUM_LEDS);
      if (state_n != IDLE) begin
        pat_n = seed_w[NUM_LEDS-1:0];
        dir_n = LEFT;
      end
    end
  end

  assign led = pat_q;

endmodule

// File: tb/tb_led_sequence_controller.sv
// Bench for led_sequence_controller: directed scenarios plus random switch
// activity, every cycle compared against a behavioural step-index model.
module tb_led_sequence_controller;

  localparam int N    = 4;
  localparam int STEP = 3;
  localparam int DEB  = 4;

  logic         sysclk_p;
  logic         sysclk_n;
  logic         rst;
  logic [1:0]   sw;
  logic [N-1:0] led;

  int checks = 0;
  int errors = 0;

  // Switch-path model: two sync stages, accepted level, previous level, release pulse
  bit [1:0] m_s1, m_s2, m_lvl, m_lprev, m_rel;
  int       m_run [2];
  // Sequencer model: 0 idle, 1 run, 2 pause; k = steps taken since the last seed
  int       m_state, m_mode, m_k, m_cnt;

  led_sequence_controller #(
    .NUM_LEDS        (N),
    .DEBOUNCE_CYCLES (DEB),
    .STEP_CYCLES     (STEP)
  ) dut (
    .sysclk_p (sysclk_p),
    .sysclk_n (sysclk_n),
    .rst      (rst),
    .sw       (sw),
    .led      (led)
  );

  initial begin
    sysclk_p = 1'b0;
    sysclk_n = 1'b1;
    forever begin
      #5 sysclk_n = 1'b0; sysclk_p = 1'b1;
      #5 sysclk_p = 1'b0; sysclk_n = 1'b1;
    end
  end

  function automatic logic [N-1:0] exp_led();
    int p, pos;
    if (m_state == 0) return '0;
    case (m_mode)
      0: return N'(1) << (m_k % N);
      1: return N'(m_k);
      2: begin
        p   = m_k % (2 * N - 2);
        pos = (p < N) ? p : (2 * N - 2 - p);
        return N'(1) << pos;
      end
      default: return (m_k % 2 == 1) ? '1 : '0;
    endcase
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lprev = '0; m_rel = '0;
    m_run[0] = 0; m_run[1] = 0;
    m_state = 0; m_mode = 0; m_k = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input logic [1:0] sv);
    bit r0, r1;
    r0 = m_rel[0];
    r1 = m_rel[1];
    for (int i = 0; i < 2; i++) begin
      m_rel[i]   = m_lprev[i] & ~m_lvl[i];
      m_lprev[i] = m_lvl[i];
`ifdef LED_SEQ_DEBOUNCE_EN
      if (m_s2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_lvl[i] = m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_s2[i] = m_s1[i];
      m_s1[i] = sv[i];
`else
      m_s2[i]  = m_s1[i];
      m_s1[i]  = sv[i];
      m_lvl[i] = m_s2[i];
`endif
    end
    case (m_state)
      0: if (r0) begin m_state = 1; m_k = 0; m_cnt = 0; end
      1: begin
        if (m_cnt == STEP - 1) begin m_cnt = 0; m_k++; end
        else m_cnt++;
        if (r0) m_state = 2;
      end
      default: if (r0) m_state = 1;
    endcase
    if (r1) begin
      m_mode = (m_mode + 1) % 4;
      m_cnt  = 0;
      m_k    = 0;
    end
  endtask

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  // Called at a falling edge: drive sw, advance one rising edge, compare at the next falling edge
  task automatic cycles(input int n, input logic [1:0] sv);
    for (int c = 0; c < n; c++) begin
      sw = sv;
      @(posedge sysclk_p);
      if (rst) model_reset();
      else     model_edge(sv);
      @(negedge sysclk_p);
      check("led", led, exp_led());
    end
  endtask

  task automatic async_reset_pulse(input logic [1:0] hold);
    #2 rst = 1'b1;
    #1 check("async_rst_led", led, '0);
    model_reset();
    @(negedge sysclk_p);
    cycles(2, hold);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    sw  = 2'b00;
    model_reset();
    @(negedge sysclk_p);
    check("reset_led", led, '0);
    cycles(3, 2'b00);
    rst = 1'b0;

    // Start in chaser mode
    cycles(8, 2'b01);
    cycles(30, 2'b00);
    // Pause, hold, then resume
    cycles(8, 2'b01);
    cycles(28, 2'b00);
    cycles(8, 2'b01);
    cycles(20, 2'b00);
    // Two mode advances while running: bounce
    cycles(8, 2'b10);
    cycles(8, 2'b00);
    cycles(8, 2'b10);
    cycles(40, 2'b00);

    // Short glitch from idle
    async_reset_pulse(2'b00);
    cycles(4, 2'b00);
    cycles(2, 2'b01);
    cycles(20, 2'b00);

    // Both switches released together from idle: counter mode, run through a wrap
    async_reset_pulse(2'b00);
    cycles(8, 2'b11);
    cycles(60, 2'b00);

    // Into blink, then reset mid-run with sw[0] held high through reset
    cycles(8, 2'b10);
    cycles(8, 2'b00);
    cycles(8, 2'b10);
    cycles(20, 2'b00);
    sw = 2'b01;
    cycles(3, 2'b01);
    async_reset_pulse(2'b01);
    cycles(20, 2'b01);
    check("held_through_reset", led, '0);
    cycles(20, 2'b00);

    // Random switch activity with occasional resets
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 19) == 0) async_reset_pulse(2'($urandom_range(0, 3)));
      cycles(int'($urandom_range(1, 12)), 2'($urandom_range(0, 3)));
    end
    cycles(30, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_sequence_controller.md
# led_sequence_controller

Board-level controller that drives the LED bank as a sequenced resource: two slide switches are synchronized, debounced and edge-detected, and a run/pause state machine steps one of four LED patterns at a fixed step rate. It replaces single-LED direct toggling in the top level. It owns the differential clock buffer and is the only driver of `led`.

## Interface
- `NUM_LEDS`, 8: width of LED bank; legal range 2..16.
- `DEBOUNCE_CYCLES`, 2_000_000: consecutive stable samples required to accept a switch level (10 ms at 200 MHz).
- `STEP_CYCLES`, 50_000_000: clock cycles per pattern step while running.
- `sysclk_p`  in  1  differential system clock, positive leg; with `sysclk_n`, buffered by `IBUFGDS` to internal `s_clk`, the only clock.
- `sysclk_n`  in  1  differential system clock, negative leg.
- `rst`  in  1  reset, asynchronous, active-high.
- `sw`  in  2  raw switches; `sw[0]` run/pause, `sw[1]` mode advance; asynchronous to `s_clk`.
- `led`  out  NUM_LEDS  registered pattern output.

## Operation
- Per switch: 2-FF synchronizer, then debouncer, then release detector. Release = debounced level 1→0. Produces a one-cycle pulse: `rel0` for `sw[0]`, `rel1` for `sw[1]`.
- Debouncer: counter clears whenever the synchronized value equals the debounced level. Otherwise it increments; on reaching DEBOUNCE_CYCLES−1 the debounced level takes the synchronized value and the counter clears.
- States:
  - IDLE: `led` = 0, step counter held at 0.
  - RUN: step counter counts 0..STEP_CYCLES−1 and wraps; at the terminal count the pattern advances one step.
  - PAUSE: `led` and step counter frozen.
- Transitions on `rel0`: IDLE→RUN (pattern loaded with the current mode's seed, step counter 0); RUN→PAUSE; PAUSE→RUN (resume from the frozen step count). Only `rst` returns the block to IDLE.
- `rel1` in any state: mode ← (mode+1) mod 4, step counter ← 0; state unchanged. In RUN/PAUSE the pattern reloads the new seed; in IDLE `led` stays 0.
- Simultaneous `rel0` and `rel1`: apply both; the resulting state uses the new mode's seed with step counter 0.
- `rel1` coinciding with step terminal count: seed reload wins, no advance.
- Modes, with seed and step rule:
  - 0 chaser: seed 0…01; rotate left, MSB wraps to LSB.
  - 1 counter: seed 0; increment mod 2^NUM_LEDS, wraps all-ones→0.
  - 2 bounce: seed 0…01, direction left; shift one position in the current direction. Direction reverses on reaching the MSB or LSB, so the next step moves away from the end.
  - 3 blink: seed 0; bitwise invert.

## Timing
- Reset values: `led` = 0, state IDLE, mode 0, direction left, all counters 0, synchronizer and debounced levels 0.
- With debounce: a switch level stable from cycle t is accepted at t+2+DEBOUNCE_CYCLES, the release pulse follows one cycle later, and `led` updates the next cycle. Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Without debounce: `led` updates 4 cycles after the raw falling edge.
- Step period is exactly STEP_CYCLES cycles in RUN. Time spent in PAUSE does not count.
- `rst` mid-sequence: every register returns to its reset value immediately. A switch held high across reset produces no release until it is seen high after reset and then released.

## Configuration
- `LED_SEQ_DEBOUNCE_EN` defined: debouncer instantiated as above.
- Undefined: the debounced level equals the synchronizer output (no counter), and DEBOUNCE_CYCLES is ignored. Used for fast simulation and small benches.

## Structure
- Package `led_seq_pkg`:
  - state enum IDLE/RUN/PAUSE;
  - mode enum CHASE/COUNT/BOUNCE/BLINK;
  - mode-count constant;
  - seed function of mode and NUM_LEDS.
- Sub-module `switch_debouncer`: synchronizer, optional debounce counter, release pulse; instantiated once per switch.
- Top: `IBUFGDS`, FSM, step counter, pattern register.

## Test plan
Bench parameters: NUM_LEDS=4, STEP_CYCLES=3, DEBOUNCE_CYCLES=4; run with and without `LED_SEQ_DEBOUNCE_EN`.
- Reset, then `sw[0]` pulse high 8 cycles and low → RUN, `led` = 0001, then 0010, 0100, 1000, 0001 every 3 cycles.
- Release `sw[0]` again while in RUN → `led` frozen for 20 cycles. Third release → stepping resumes with the step count intact.
- Release `sw[1]` twice in RUN → mode 2 (bounce): 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- 2-cycle glitch on `sw[0]` with debounce enabled → no state change. Same glitch with debounce disabled → RUN.
- Release both switches in the same cycle from IDLE → RUN in mode 1, `led` = 0000, then 0001 after 3 cycles. Mode 1 wraps from 1111 to 0000.
- Assert `rst` mid-RUN in mode 3 → `led` = 0000, state IDLE, mode 0 in the same cycle. No release occurs while `sw[0]` is held high through reset.
